// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush and data-memory freeze.
// Optional HAZARD_PERF_EN enables the saturating stall-cycle counter on stall_cnt_o.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RDaddr_i,
  input  logic [4:0]  IFID_RS1addr_i,
  input  logic [4:0]  IFID_RS2addr_i,
  input  logic        Branch_taken_i,
  input  logic        EXMEM_MemRead_i,
  input  logic        EXMEM_MemWrite_i,
  input  logic        mem_ack_i,
  output logic        PC_write_o,
  output logic        IFID_write_o,
  output logic        IFID_flush_o,
  output logic        IDEX_write_o,
  output logic        IDEX_bubble_o,
  output logic        EXMEM_write_o,
  output logic        MEMWB_bubble_o,
  output logic        mem_req_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o
);
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              mem_acc;
  logic              load_use;

  assign mem_acc  = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign load_use = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                    ((IDEX_RDaddr_i == IFID_RS1addr_i) || (IDEX_RDaddr_i == IFID_RS2addr_i));

  // Next state and Mealy pipeline controls
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    err_d          = err_q;
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_write_o   = 1'b1;
    IDEX_bubble_o  = 1'b0;
    EXMEM_write_o  = 1'b1;
    MEMWB_bubble_o = 1'b0;
    mem_req_o      = mem_acc;

    if (rst_i) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IFID_flush_o   = 1'b1;
      IDEX_write_o   = 1'b0;
      IDEX_bubble_o  = 1'b1;
      EXMEM_write_o  = 1'b0;
      MEMWB_bubble_o = 1'b1;
      mem_req_o      = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_acc && !mem_ack_i) begin
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IDEX_write_o   = 1'b0;
            EXMEM_write_o  = 1'b0;
            MEMWB_bubble_o = 1'b1;
            state_d        = MEM_WAIT;
            wait_cnt_d     = '0;
          end else if (load_use) begin
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
          end else if (Branch_taken_i) begin
            IFID_flush_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          mem_req_o = 1'b1;
          if (mem_ack_i) begin
            state_d = RUN;
          end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
            // Abort: release the pipe but keep the lost access out of MEM/WB
            MEMWB_bubble_o = 1'b1;
            err_d          = 1'b1;
            state_d        = RUN;
          end else begin
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IDEX_write_o   = 1'b0;
            EXMEM_write_o  = 1'b0;
            MEMWB_bubble_o = 1'b1;
            wait_cnt_d     = wait_cnt_q + WAIT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles with the PC held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against an outstanding-access-age model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst;
  logic mr, br, emr, emw, ack;
  logic [4:0] rd, rs1, rs2;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, req, err;
  logic [15:0] scnt;

  int total = 0;
  int bad   = 0;

  // Model: age = cycles the current memory access has been outstanding (0 = none)
  int unsigned age   = 0;
  bit          m_err = 1'b0;
  int unsigned m_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .IDEX_MemRead_i(mr), .IDEX_RDaddr_i(rd),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
    .Branch_taken_i(br),
    .EXMEM_MemRead_i(emr), .EXMEM_MemWrite_i(emw), .mem_ack_i(ack),
    .PC_write_o(pc_w), .IFID_write_o(ifid_w), .IFID_flush_o(ifid_f),
    .IDEX_write_o(idex_w), .IDEX_bubble_o(idex_b), .EXMEM_write_o(exmem_w),
    .MEMWB_bubble_o(memwb_b), .mem_req_o(req), .err_o(err), .stall_cnt_o(scnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic b, input logic lr, input logic lw,
                       input logic a);
    rst = r; mr = m; rd = d; rs1 = s1; rs2 = s2; br = b; emr = lr; emw = lw; ack = a;
  endtask

  // Check one cycle against the model, advance the model, move to the next negedge
  task automatic step();
    logic e_pc, e_ifw, e_iff, e_idw, e_idb, e_exw, e_mwb, e_req;
    logic acc, active, lu;
    #1;
    acc    = emr | emw;
    active = (age > 0) || (acc && !ack);
    lu     = mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    if (rst) begin
      {e_pc, e_ifw, e_iff, e_idw, e_idb, e_exw, e_mwb, e_req} = 8'b0010_1010;
    end else begin
      {e_pc, e_ifw, e_iff, e_idw, e_idb, e_exw, e_mwb} = 7'b1101_010;
      e_req = acc;
      if (active) begin
        e_req = 1'b1;
        if (ack) begin
          // release: hazards are not evaluated on the release cycle
        end else if (age == T + 1) begin
          e_mwb = 1'b1;
        end else begin
          e_pc = 1'b0; e_ifw = 1'b0; e_idw = 1'b0; e_exw = 1'b0; e_mwb = 1'b1;
        end
      end else if (lu) begin
        e_pc = 1'b0; e_ifw = 1'b0; e_idb = 1'b1;
      end else if (br) begin
        e_iff = 1'b1;
      end
    end
    chk("ctrl", 32'({pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, req}),
        32'({e_pc, e_ifw, e_iff, e_idw, e_idb, e_exw, e_mwb, e_req}));
    chk("err", 32'(err), 32'(m_err));
    chk("stall_cnt", 32'(scnt), m_cnt);
    if (rst) begin
      age = 0; m_err = 1'b0; m_cnt = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (!e_pc && m_cnt < 65535) m_cnt++;
`endif
      if (active && !ack && age == T + 1) m_err = 1'b1;
      if (active && !ack && age <= T) age++;
      else age = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    step();
    step();
    // load-use on rs1, then release; rd=x0 never stalls
    drive(0, 1, 5, 5, 0, 0, 0, 0, 0); step();
    drive(0, 0, 5, 5, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
    // load-use beats branch; branch held next cycle flushes
    drive(0, 1, 5, 0, 5, 1, 0, 0, 0); step();
    drive(0, 0, 5, 0, 5, 1, 0, 0, 0); step();
    // store acked after 3 cycles
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    // load never acked: timeout after T+1 frozen cycles
    for (int i = 0; i < int'(T) + 2; i++) begin drive(0, 0, 0, 0, 0, 1, 1, 0, 0); step(); end
    chk("err_sticky", 32'(err), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("err_hold", 32'(err), 32'd1);
    // reset in the middle of a wait
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("err_cleared", 32'(err), 32'd0);
    step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      step();
    end
    // long continuous stall to reach counter saturation
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 7, 7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step();
`ifdef HAZARD_PERF_EN
    chk("stall_sat", 32'(scnt), 32'hFFFF);
`else
    chk("stall_off", 32'(scnt), 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards between ID/EX and IF/ID.
- Applies the ID-stage branch flush.
- Runs a request/acknowledge handshake with the data memory for the load or store currently held in EX/MEM, freezing the pipeline until the access completes or times out.
- Drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- MEM_TIMEOUT, 255: max MEM_WAIT cycles before abort; legal range 1..255.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_RDaddr_i  in  5  destination register of instruction in EX.
- IFID_RS1addr_i  in  5  rs1 of instruction in ID.
- IFID_RS2addr_i  in  5  rs2 of instruction in ID.
- Branch_taken_i  in  1  branch in ID resolved taken.
- EXMEM_MemRead_i  in  1  EX/MEM holds a load.
- EXMEM_MemWrite_i  in  1  EX/MEM holds a store.
- mem_ack_i  in  1  data memory completes the access this cycle.
- PC_write_o  out  1  PC update enable.
- IFID_write_o  out  1  IF/ID load enable.
- IFID_flush_o  out  1  IF/ID loads a NOP.
- IDEX_write_o  out  1  ID/EX load enable.
- IDEX_bubble_o  out  1  ID/EX loads zeroed control bits.
- EXMEM_write_o  out  1  EX/MEM load enable.
- MEMWB_bubble_o  out  1  MEM/WB loads zeroed control bits.
- mem_req_o  out  1  data memory access request.
- err_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  16  stall-cycle performance counter.

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- Outputs are Mealy: a combinational function of state and current inputs.
- mem_acc = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- RUN, mem_acc=1:
  - mem_req_o=1.
  - mem_ack_i=1: proceed normally (zero-wait access), stay in RUN.
  - mem_ack_i=0: freeze this cycle (same outputs as MEM_WAIT), next state MEM_WAIT.
- MEM_WAIT:
  - mem_req_o=1.
  - PC_write_o=IFID_write_o=IDEX_write_o=EXMEM_write_o=0.
  - MEMWB_bubble_o=1.
  - All hazard and branch inputs ignored.
  - mem_ack_i=1: release that cycle (all enables 1, no bubble), next state RUN.
- Timeout:
  - wait_cnt (8 bit) clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
  - When wait_cnt == MEM_TIMEOUT with mem_ack_i=0: set err_o, release as if acked, go to RUN.
  - The aborted access's MEM/WB stays bubbled.
- Load-use stall (RUN, no memory freeze) is asserted when all of:
  - IDEX_MemRead_i=1.
  - IDEX_RDaddr_i != 0.
  - IDEX_RDaddr_i equals IFID_RS1addr_i or IFID_RS2addr_i.
- Load-use response: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1. Lasts exactly one cycle, since the bubble clears the condition.
- Branch flush (RUN, no freeze, no load-use): Branch_taken_i=1 gives IFID_flush_o=1.
- Priority: memory freeze > load-use stall > branch flush.
  - Branch_taken_i coincident with load-use is dropped; ID re-resolves it next cycle.
- Default in RUN with no event: all write enables 1, all bubbles and flush 0, mem_req_o=mem_acc.

## Timing
- While rst_i=1:
  - All write enables 0.
  - IDEX_bubble_o=MEMWB_bubble_o=IFID_flush_o=1.
  - mem_req_o=0.
- At the first rising edge with rst_i=1: state=RUN, wait_cnt=0, err_o=0, stall_cnt_o=0.
- Reset asserted during MEM_WAIT returns to RUN in one edge. No pending request is remembered.
- Load-use penalty: 1 cycle.
- Memory penalty: N cycles, where ack arrives N cycles after first request; 0 for same-cycle ack.
- Maximum freeze: MEM_TIMEOUT+1 cycles.
- err_o rises on the edge ending the timeout cycle and stays high until reset.
- stall_cnt_o increments once per cycle in which PC_write_o=0 (rst_i=0). It saturates at 16'hFFFF; no wrap.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt_o is a live 16-bit saturating counter.
- HAZARD_PERF_EN undefined: no counter register; stall_cnt_o tied to 16'h0000.
- Stall and flush behaviour is identical in both builds.

## Test plan
- Load x5 in EX, ID uses rs1=x5 -> 1 cycle with PC_write_o=0 and IDEX_bubble_o=1; next cycle all enables 1. Repeat with rd=x0 -> no stall.
- Load-use and Branch_taken_i in the same cycle -> stall only, IFID_flush_o=0. Branch held next cycle -> IFID_flush_o=1.
- Store in EX/MEM, mem_ack_i after 3 cycles -> mem_req_o high 4 cycles, enables low 3 cycles, stall_cnt_o=3.
- MEM_TIMEOUT=4, mem_ack_i never asserted -> release after 5 frozen cycles, err_o=1 sticky, state RUN.
- rst_i pulsed mid-MEM_WAIT -> next cycle mem_req_o=0 and err_o=0. After release, enables resume 1 in RUN.
- 70000 consecutive stall cycles with HAZARD_PERF_EN defined -> stall_cnt_o=16'hFFFF. With the macro undefined -> stall_cnt_o=0.
